// File: rtl/instr_issue.sv
// Program buffer that is loaded word by word while idle, then replayed as
// one-cycle issue strobes spaced GAP idle cycles apart until the execution side ends the run.
//
// state      | meaning
// S_IDLE     | accept program writes / clear, wait for start
// S_RUN      | issuing stored words, one every GAP+1 cycles
// S_WAIT_END | all words issued, waiting for computation_end
// S_DONE     | one-cycle done pulse, back to S_IDLE
module instr_issue #(
    parameter int DATA_LEN = 16,
    parameter int DEPTH    = 16,
    parameter int GAP      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_LEN-1:0]       wr_data,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      computation_end,
    output logic                      rd,
    output logic [DATA_LEN-1:0]       data_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] GAP_LD = 8'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_END, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]       idx;
    logic [7:0]          gap_cnt;
    logic                issue, last_word, do_write, do_start;

    assign full      = (count == CW'(DEPTH));
    assign issue     = (state == S_RUN) && (gap_cnt == 8'd0);
    assign last_word = ({1'b0, idx} == count - CW'(1));
    // clear outranks wr_en, and wr_en outranks start
    assign do_write  = (state == S_IDLE) && !clear && wr_en && !full;
    assign do_start  = (state == S_IDLE) && !clear && !wr_en && start && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        data_out  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (do_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                rd   = issue;
                if (issue) data_out = mem[idx];
                if (computation_end)         state_nxt = S_DONE;
                else if (issue && last_word) state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                busy = 1'b1;
                if (computation_end) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (clear)         count <= '0;
            else if (do_write) count <= count + CW'(1);
            if (do_start) begin
                idx     <= '0;
                gap_cnt <= '0;
            end
        end else if (state == S_RUN) begin
            if (issue) begin
                if (!last_word && !computation_end) begin
                    idx     <= idx + AW'(1);
                    gap_cnt <= GAP_LD;
                end
            end else begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    // Storage is not reset: count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_write) mem[count[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: two instances (GAP=0 and GAP=2) share stimulus and are
// checked every cycle against an arithmetic reference model, plus directed sequences.
module tb_instr_issue;

    logic        clk, rst;
    logic        wr_en, clear, start, ce;
    logic [15:0] wr_data;

    logic        rd0, full0, busy0, done0, rd2, full2, busy2, done2;
    logic [15:0] dout0, dout2;
    logic [4:0]  cnt0, cnt2;

    instr_issue #(.DATA_LEN(16), .DEPTH(16), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .start(start), .computation_end(ce), .rd(rd0), .data_out(dout0),
        .count(cnt0), .full(full0), .busy(busy0), .done(done0));

    instr_issue #(.DATA_LEN(16), .DEPTH(16), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .start(start), .computation_end(ce), .rd(rd2), .data_out(dout2),
        .count(cnt2), .full(full2), .busy(busy2), .done(done2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 issuing, 2 waiting for end, 3 done pulse.
    // Issue timing is derived from the cycle distance to the first issue cycle.
    int          cyc;
    int          m_mode [2];
    int          m_t0   [2];
    int          m_cnt  [2];
    logic [15:0] m_mem  [2][16];
    int          gapv   [2] = '{0, 2};

    function automatic logic exp_rd(int i);
        return (m_mode[i] == 1) && (((cyc - m_t0[i]) % (gapv[i] + 1)) == 0);
    endfunction

    function automatic int exp_word(int i);
        return (cyc - m_t0[i]) / (gapv[i] + 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_cnt[i]  = 0;
            m_t0[i]   = 0;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            logic        e_rd;
            logic [15:0] e_d;
            e_rd = exp_rd(i);
            e_d  = e_rd ? m_mem[i][exp_word(i)] : 16'h0;
            chk($sformatf("g%0d rd", gapv[i]),    i ? rd2   : rd0,   e_rd);
            chk($sformatf("g%0d data", gapv[i]),  i ? dout2 : dout0, e_d);
            chk($sformatf("g%0d count", gapv[i]), i ? cnt2  : cnt0,  m_cnt[i]);
            chk($sformatf("g%0d full", gapv[i]),  i ? full2 : full0, m_cnt[i] == 16);
            chk($sformatf("g%0d busy", gapv[i]),  i ? busy2 : busy0, m_mode[i] == 1 || m_mode[i] == 2);
            chk($sformatf("g%0d done", gapv[i]),  i ? done2 : done0, m_mode[i] == 3);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            logic r;
            r = exp_rd(i);
            case (m_mode[i])
                0: begin
                    if (clear) m_cnt[i] = 0;
                    else if (wr_en) begin
                        if (m_cnt[i] < 16) begin
                            m_mem[i][m_cnt[i]] = wr_data;
                            m_cnt[i]++;
                        end
                    end else if (start && m_cnt[i] > 0) begin
                        m_mode[i] = 1;
                        m_t0[i]   = cyc + 1;
                    end
                end
                1: begin
                    if (ce) m_mode[i] = 3;
                    else if (r && exp_word(i) == m_cnt[i] - 1) m_mode[i] = 2;
                end
                2: if (ce) m_mode[i] = 3;
                default: m_mode[i] = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic commit();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        commit();
    endtask

    task automatic idle_in();
        wr_en = 0; clear = 0; start = 0; ce = 0; wr_data = 16'h0;
    endtask

    task automatic write(input logic [15:0] d);
        wr_en = 1; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic drain();
        ce = 1; tick(); tick();
        ce = 0; tick(); tick();
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        clr;
        logic        st;
        logic        cend;
        logic        e_rd;
        logic [15:0] e_d;
        logic        e_busy;
        logic        e_done;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl [11];
    int   pulses;

    initial begin
        rst = 0;
        idle_in();
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd", rd0, 0);
        chk("reset data", dout0, 0);
        chk("reset count", cnt0, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset full", full0, 0);
        rst = 1;

        // three-word program with GAP=0, then end of computation after WAIT
        tbl[0]  = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0};
        tbl[1]  = '{1'b1, 16'h4002, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd1};
        tbl[2]  = '{1'b1, 16'h0103, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd2};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd3};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 5'd3};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4002, 1'b1, 1'b0, 5'd3};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0103, 1'b1, 1'b0, 5'd3};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd3};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd3};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd3};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd3};
        for (int r = 0; r < 11; r++) begin
            wr_en = tbl[r].wr; wr_data = tbl[r].wd; clear = tbl[r].clr;
            start = tbl[r].st; ce = tbl[r].cend;
            sample();
            chk($sformatf("tbl%0d rd", r),    rd0,   tbl[r].e_rd);
            chk($sformatf("tbl%0d data", r),  dout0, tbl[r].e_d);
            chk($sformatf("tbl%0d busy", r),  busy0, tbl[r].e_busy);
            chk($sformatf("tbl%0d done", r),  done0, tbl[r].e_done);
            chk($sformatf("tbl%0d count", r), cnt0,  tbl[r].e_cnt);
            commit();
        end
        idle_in();

        // GAP=2 spacing: issue at cycles 1 and 4 only
        clear = 1; tick(); clear = 0;
        write(16'h1111);
        write(16'h2222);
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 5; c++) begin
            sample();
            chk($sformatf("gap c%0d rd", c), rd2, (c == 1 || c == 4));
            chk($sformatf("gap c%0d data", c), dout2,
                (c == 1) ? 16'h1111 : (c == 4) ? 16'h2222 : 16'h0000);
            commit();
        end
        drain();

        // fill to DEPTH, overflow write ignored, clear beats wr_en
        clear = 1; tick(); clear = 0;
        for (int k = 0; k < 17; k++) write(16'(16'h0300 + k));
        sample();
        chk("fill count", cnt0, 16);
        chk("fill full", full0, 1);
        commit();
        clear = 1; wr_en = 1; wr_data = 16'hDEAD;
        tick();
        idle_in();
        sample();
        chk("clear+wr count", cnt0, 0);
        chk("clear+wr full", full0, 0);
        commit();

        // abort during 2nd issue, then replay from index 0
        for (int k = 0; k < 4; k++) write(16'(16'hA000 + k));
        start = 1; tick(); start = 0;
        pulses = 0;
        for (int c = 1; c <= 6; c++) begin
            ce = (c == 2);
            sample();
            if (rd0) pulses++;
            if (c == 3) chk("abort done", done0, 1);
            commit();
        end
        ce = 0;
        chk("abort pulses", pulses, 2);
        start = 1; tick(); start = 0;
        pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            sample();
            if (rd0) begin
                chk($sformatf("replay word%0d", pulses), dout0, 16'(16'hA000 + pulses));
                pulses++;
            end
            commit();
        end
        chk("replay pulses", pulses, 4);
        drain();

        // start on empty buffer, start while running
        clear = 1; tick(); clear = 0;
        start = 1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("empty start busy", busy0, 0);
            chk("empty start done", done0, 0);
            commit();
        end
        start = 0;
        write(16'h0011);
        write(16'h0022);
        start = 1; tick();
        pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (rd0) pulses++;
            commit();
        end
        start = 0;
        chk("restart ignored pulses", pulses, 2);
        drain();

        // reset mid-run after the first of three words
        clear = 1; tick(); clear = 0;
        write(16'h0A01); write(16'h0A02); write(16'h0A03);
        start = 1; tick(); start = 0;
        tick();
        rst = 0;
        #1;
        chk("rst rd", rd0, 0);
        chk("rst data", dout0, 0);
        chk("rst count", cnt0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst g2 busy", busy2, 0);
        #1;
        rst = 1;
        model_reset();
        write(16'h5555);
        sample();
        chk("post-rst write count", cnt0, 1);
        commit();
        repeat (4) tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr_en   = ($urandom_range(99) < 30);
            clear   = ($urandom_range(99) < 3);
            start   = ($urandom_range(99) < 12);
            ce      = ($urandom_range(99) < 8);
            wr_data = 16'($urandom);
            if ($urandom_range(499) == 0) begin
                rst = 0;
                #1;
                rst = 1;
                model_reset();
            end
            tick();
        end
        idle_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 16, instruction word width; bit layout per REQ-011.
REQ-002 The block SHALL have parameter DEPTH, default 16, program buffer entries; power of two, minimum 2.
REQ-003 The block SHALL have parameter GAP, default 0, idle cycles inserted between consecutive issued words; range 0..255.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; asynchronous assert, active-low.
REQ-006 The block SHALL have port wr_en  input  1  program-load strobe.
REQ-007 The block SHALL have port wr_data  input  DATA_LEN  program word to store.
REQ-008 The block SHALL have port clear  input  1  empties the program buffer.
REQ-009 The block SHALL have port start  input  1  begins issuing the stored program.
REQ-010 The block SHALL have port computation_end  input  1  end-of-computation flag from the execution side.
REQ-011 The block SHALL have port rd  output  1  issue strobe: data_out valid this cycle; data_out bit DATA_LEN-1..DATA_LEN-8 = r,e,o1,o2,w1,w2,reset,next; bits DATA_LEN-9..0 = op.
REQ-012 The block SHALL have port data_out  output  DATA_LEN  issued instruction word.
REQ-013 The block SHALL have port count  output  log2(DEPTH)+1  number of stored words.
REQ-014 The block SHALL have port full  output  1  count == DEPTH.
REQ-015 The block SHALL have port busy  output  1  high in RUN and WAIT_END.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse at end of a run.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, WAIT_END, DONE.
REQ-018 In IDLE, wr_en with full=0 SHALL store wr_data at index count and increment count next cycle; wr_en with full=1 SHALL be ignored.
REQ-019 wr_en and clear outside IDLE SHALL be ignored; the program SHALL be retained across runs (replayable).
REQ-020 clear in IDLE SHALL set count to 0 next cycle and SHALL take priority over a simultaneous wr_en and start.
REQ-021 start in IDLE with count>0 SHALL move to RUN next cycle with issue index 0; start with count==0 or outside IDLE SHALL be ignored; start and wr_en together SHALL perform only the write.
REQ-022 In RUN, rd SHALL be high for exactly one cycle per word, data_out = buffer[index]; the first rd SHALL occur in the first RUN cycle (latency 1 cycle from start).
REQ-023 After each rd, the next rd SHALL follow exactly GAP+1 cycles later; rd SHALL be low in gap cycles.
REQ-024 After the rd of word count-1, the FSM SHALL enter WAIT_END the next cycle.
REQ-025 computation_end high in RUN SHALL abort: no further rd; DONE next cycle (a rd in the same cycle still completes).
REQ-026 In WAIT_END, computation_end high SHALL move to DONE next cycle; otherwise remain indefinitely.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE next cycle.
REQ-028 data_out SHALL be 0 whenever rd is low.
REQ-029 count SHALL never exceed DEPTH; index SHALL never wrap past count-1.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, count=0, index=0, gap counter=0, rd=0, data_out=0, busy=0, done=0, full=0.
REQ-031 rst asserted mid-RUN SHALL abort the run with no further rd and discard the program; no done pulse SHALL be produced.
REQ-032 After rst deasserts, the block SHALL accept wr_en on the first following rising edge.

Verification
REQ-033 Load 0x8001,0x4002,0x0103, start, GAP=0 -> rd high cycles 1-3 after start with data_out 0x8001,0x4002,0x0103; busy high; computation_end 2 cycles later -> done pulse, busy low.
REQ-034 GAP=2, 2 words, start -> rd at cycle 1 and 4 only; data_out 0 in cycles 2,3.
REQ-035 DEPTH=16: 17 writes -> full after 16th, count=16, 17th ignored; clear+wr_en same cycle -> count=0.
REQ-036 4 words, computation_end during 2nd rd -> exactly 2 rd pulses, done next cycle; start again -> all 4 words replayed from index 0.
REQ-037 start with count=0 -> stays IDLE, no rd, no done; start during RUN -> ignored.
REQ-038 rst low mid-RUN after 1st of 3 words -> rd=0 immediately, count=0, busy=0, no done.
